// File: rtl/iic_pkg.sv
// Shared types and helpers for the window-scan datapath (controller, register
// array, OPU bus packing).
package iic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_FIN     = 2'd3
  } scan_state_e;

  localparam int unsigned NBIT = 8;

  // Tap (row r, col c) of the 3x3 window maps to bit 8-(3r+c).
  function automatic logic [3:0] tap_idx(input int unsigned r, input int unsigned c);
    return 4'(8 - (3 * r + c));
  endfunction

endpackage

// File: rtl/win_snake_gen.sv
// Window coordinate generator: walks two-column strips in snake order and
// flags the final window of the scan.
module win_snake_gen #(
  parameter int unsigned PS_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [PS_W-1:0]      pic_size,
  input  logic                 padding,
  output logic [PS_W-1:0]      win_x,
  output logic [PS_W-1:0]      win_y,
  output logic signed [PS_W:0] nxt_x,
  output logic signed [PS_W:0] nxt_y,
  output logic                 last
);

  localparam int unsigned CW = PS_W + 1;

  logic [CW-1:0]        nc_q, nc_d;
  logic [CW-1:0]        strip_q, strip_d;
  logic [CW-1:0]        row_q, row_d;
  logic                 sec_q, sec_d;
  logic                 pad_q, pad_d;
  logic signed [CW-1:0] x_q, x_d;
  logic signed [CW-1:0] y_q, y_d;

  logic [CW-1:0] two_s;
  logic          single_col;
  logic          last_strip;
  logic          last_row;

  assign two_s      = {strip_q[CW-2:0], 1'b0};
  assign single_col = (two_s + CW'(1)) >= nc_q;
  assign last_strip = (two_s + CW'(2)) >= nc_q;
  assign last_row   = row_q == (nc_q - CW'(1));
  assign last       = last_strip && last_row && (single_col || sec_q);

  always_comb begin
    nc_d    = nc_q;
    strip_d = strip_q;
    row_d   = row_q;
    sec_d   = sec_q;
    pad_d   = pad_q;
    x_d     = x_q;
    y_d     = y_q;
    if (load) begin
      pad_d   = padding;
      nc_d    = CW'(pic_size) - CW'(2) + (padding ? CW'(2) : '0);
      strip_d = '0;
      row_d   = '0;
      sec_d   = 1'b0;
      x_d     = padding ? '1 : '0;
      y_d     = padding ? '1 : '0;
    end else if (advance) begin
      if (!single_col && !sec_q) begin
        // Even rows step right, odd rows step left within the strip.
        sec_d = 1'b1;
        x_d   = row_q[0] ? x_q - CW'(1) : x_q + CW'(1);
      end else if (last_row) begin
        strip_d = strip_q + CW'(1);
        row_d   = '0;
        sec_d   = 1'b0;
        y_d     = pad_q ? '1 : '0;
        x_d     = $signed(two_s + CW'(2)) - $signed(CW'(pad_q));
      end else begin
        // Next row begins on the column the previous row ended on.
        row_d = row_q + CW'(1);
        sec_d = 1'b0;
        y_d   = y_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nc_q    <= '0;
      strip_q <= '0;
      row_q   <= '0;
      sec_q   <= 1'b0;
      pad_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      nc_q    <= nc_d;
      strip_q <= strip_d;
      row_q   <= row_d;
      sec_q   <= sec_d;
      pad_q   <= pad_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign win_x = x_q[PS_W-1:0];
  assign win_y = y_q[PS_W-1:0];
  assign nxt_x = x_d;
  assign nxt_y = y_d;

endmodule

// File: rtl/win_scan_ctrl.sv
// Window-scan sequencer: per window position, per bit plane, one register-array
// fetch followed by one OPU beat, with the padded-tap mask.
module win_scan_ctrl #(
  parameter int unsigned PS_W = 8,
  parameter int unsigned NBIT = iic_pkg::NBIT
) (
  input  logic            SYS_CLK,
  input  logic            SYS_RST,
  input  logic            START,
  input  logic [PS_W-1:0] PIC_SIZE,
  input  logic            PADDING,
  output logic            FETCH_REQ,
  input  logic            FETCH_ACK,
  output logic            OPU_VLD,
  input  logic            OPU_RDY,
  output logic [PS_W-1:0] WIN_X,
  output logic [PS_W-1:0] WIN_Y,
  output logic [2:0]      BIT_SEL,
  output logic [8:0]      TAP_MASK,
  output logic            BUSY,
  output logic            DONE
);

  import iic_pkg::*;

  localparam int unsigned CW = PS_W + 1;

  scan_state_e          state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [8:0]           mask_q, mask_d;
  logic [PS_W-1:0]      ps_q, ps_d;
  logic                 short_q, short_d;
  logic                 load, advance, last;
  logic signed [CW-1:0] nxt_x, nxt_y;

  function automatic logic tap_out(input logic signed [CW-1:0] v, input logic [PS_W-1:0] ps);
    return v[CW-1] || (v >= $signed({1'b0, ps}));
  endfunction

  win_snake_gen #(.PS_W(PS_W)) u_gen (
    .clk      (SYS_CLK),
    .rst_n    (SYS_RST),
    .load     (load),
    .advance  (advance),
    .pic_size (PIC_SIZE),
    .padding  (PADDING),
    .win_x    (WIN_X),
    .win_y    (WIN_Y),
    .nxt_x    (nxt_x),
    .nxt_y    (nxt_y),
    .last     (last)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ps_d    = ps_q;
    short_d = 1'b0;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (START) begin
          if (PIC_SIZE >= PS_W'(3)) begin
            load    = 1'b1;
            ps_d    = PIC_SIZE;
            bit_d   = '0;
            state_d = ST_FETCH;
          end else begin
            short_d = 1'b1;
          end
        end
      end
      ST_FETCH: begin
        if (FETCH_ACK) state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (OPU_RDY) begin
          if (32'(bit_q) < NBIT - 1) begin
            bit_d   = bit_q + 3'd1;
            state_d = ST_FETCH;
          end else if (last) begin
            state_d = ST_FIN;
          end else begin
            advance = 1'b1;
            bit_d   = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Mask is computed from the generator's next coordinates so it lands in the
  // same cycle as the coordinates it describes.
  always_comb begin
    mask_d = mask_q;
    if (load || advance) begin
      for (int unsigned r = 0; r < 3; r++) begin
        for (int unsigned c = 0; c < 3; c++) begin
          mask_d[tap_idx(r, c)] = tap_out(nxt_x + $signed(CW'(c)), ps_d) ||
                                  tap_out(nxt_y + $signed(CW'(r)), ps_d);
        end
      end
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST) begin
    if (!SYS_RST) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      mask_q  <= '0;
      ps_q    <= '0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      mask_q  <= mask_d;
      ps_q    <= ps_d;
      short_q <= short_d;
    end
  end

  assign FETCH_REQ = state_q == ST_FETCH;
  assign OPU_VLD   = state_q == ST_PRESENT;
  assign BUSY      = (state_q == ST_FETCH) || (state_q == ST_PRESENT);
  assign DONE      = (state_q == ST_FIN) || short_q;
  assign BIT_SEL   = bit_q;
  assign TAP_MASK  = mask_q;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Self-checking bench for win_scan_ctrl: table of scan configurations plus
// hand-written reset, restart and degenerate-size sequences.
module tb_win_scan_ctrl;

  logic       SYS_CLK = 1'b0;
  logic       SYS_RST = 1'b0;
  logic       START = 1'b0;
  logic [7:0] PIC_SIZE = '0;
  logic       PADDING = 1'b0;
  logic       FETCH_ACK = 1'b0;
  logic       OPU_RDY = 1'b0;
  logic       FETCH_REQ, OPU_VLD, BUSY, DONE;
  logic [7:0] WIN_X, WIN_Y;
  logic [2:0] BIT_SEL;
  logic [8:0] TAP_MASK;

  win_scan_ctrl #(.PS_W(8), .NBIT(8)) dut (
    .SYS_CLK   (SYS_CLK),
    .SYS_RST   (SYS_RST),
    .START     (START),
    .PIC_SIZE  (PIC_SIZE),
    .PADDING   (PADDING),
    .FETCH_REQ (FETCH_REQ),
    .FETCH_ACK (FETCH_ACK),
    .OPU_VLD   (OPU_VLD),
    .OPU_RDY   (OPU_RDY),
    .WIN_X     (WIN_X),
    .WIN_Y     (WIN_Y),
    .BIT_SEL   (BIT_SEL),
    .TAP_MASK  (TAP_MASK),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  always #5 SYS_CLK = ~SYS_CLK;

  typedef struct { int x; int y; int b; int m; } beat_t;
  typedef struct { int ps; int pad; bit tie; int ad; int rd; int restart; int beats; } vec_t;

  beat_t exp_q[$];
  int    cmp_cnt = 0;
  int    err_cnt = 0;
  bit    tie_hi = 1'b1;
  int    ack_dly = 0, rdy_dly = 0;
  bit    mon_en = 1'b0;
  bit    check_spacing = 1'b0;
  int    idx = 0, done_cnt = 0, cyc = 0, last_beat_cyc = 0;
  int    m_first = 0, m_66 = 0, last_x = 0, last_y = 0, last_b = 0;

  task automatic chk(input string name, input int act, input int req);
    cmp_cnt++;
    if (act != req) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int exp_mask(input int x, input int y, input int ps);
    int m = 0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        if (x + c < 0 || x + c >= ps || y + r < 0 || y + r >= ps)
          m |= 1 << (8 - (3 * r + c));
    return m;
  endfunction

  task automatic build(input int ps, input int p);
    int nc, x0, xs[2], ncols;
    exp_q.delete();
    nc = ps - 2 + 2 * p;
    for (int s = 0; s < (nc + 1) / 2; s++) begin
      x0 = 2 * s - p;
      for (int r = 0; r < nc; r++) begin
        if (x0 + 1 > nc - 1 - p) begin ncols = 1; xs[0] = x0; end
        else if (r % 2 == 0) begin ncols = 2; xs[0] = x0; xs[1] = x0 + 1; end
        else begin ncols = 2; xs[0] = x0 + 1; xs[1] = x0; end
        for (int k = 0; k < ncols; k++)
          for (int b = 0; b < 8; b++)
            exp_q.push_back('{xs[k], r - p, b, exp_mask(xs[k], r - p, ps)});
      end
    end
  endtask

  // Handshake responder and monitor share one negedge loop so ordering is fixed.
  initial begin : agent
    int req_age = 0, vld_age = 0;
    bit prev_req = 0, prev_vld = 0, prev_ack = 0, prev_rdy = 0;
    int px = 0, py = 0, pb = 0, pm = 0;
    forever begin
      @(negedge SYS_CLK);
      cyc++;
      req_age = FETCH_REQ ? (prev_req ? req_age + 1 : 0) : 0;
      vld_age = OPU_VLD ? (prev_vld ? vld_age + 1 : 0) : 0;
      FETCH_ACK = tie_hi ? 1'b1 : (FETCH_REQ && req_age >= ack_dly);
      OPU_RDY   = tie_hi ? 1'b1 : (OPU_VLD && vld_age >= rdy_dly);
      if (mon_en) begin
        if (FETCH_REQ && OPU_VLD) chk("req_vld_exclusive", 1, 0);
        if ((prev_req && !prev_ack) || (prev_vld && !prev_rdy)) begin
          chk("hold_x", int'(WIN_X), px);
          chk("hold_y", int'(WIN_Y), py);
          chk("hold_bit", int'(BIT_SEL), pb);
          chk("hold_mask", int'(TAP_MASK), pm);
          chk("hold_handshake", {FETCH_REQ, OPU_VLD}, {prev_req, prev_vld});
        end
        if (prev_req && prev_ack) chk("vld_after_ack", OPU_VLD, 1);
        if (OPU_VLD && OPU_RDY) begin
          if (idx < exp_q.size()) begin
            chk($sformatf("beat%0d_x", idx), int'($signed(WIN_X)), exp_q[idx].x);
            chk($sformatf("beat%0d_y", idx), int'($signed(WIN_Y)), exp_q[idx].y);
            chk($sformatf("beat%0d_bit", idx), int'(BIT_SEL), exp_q[idx].b);
            chk($sformatf("beat%0d_mask", idx), int'(TAP_MASK), exp_q[idx].m);
          end else begin
            chk("extra_beat", idx, exp_q.size());
          end
          if (check_spacing && idx > 0) chk("beat_spacing", cyc - last_beat_cyc, 2);
          if ($signed(WIN_X) == -1 && $signed(WIN_Y) == -1) m_first = int'(TAP_MASK);
          if ($signed(WIN_X) == 6 && $signed(WIN_Y) == 6) m_66 = int'(TAP_MASK);
          last_x = int'($signed(WIN_X)); last_y = int'($signed(WIN_Y)); last_b = int'(BIT_SEL);
          last_beat_cyc = cyc;
          idx++;
        end
        if (DONE) begin
          done_cnt++;
          chk("busy_low_with_done", BUSY, 0);
          if (exp_q.size() > 0) chk("done_after_last_beat", cyc - last_beat_cyc, 1);
        end
      end
      prev_req = FETCH_REQ; prev_vld = OPU_VLD; prev_ack = FETCH_ACK; prev_rdy = OPU_RDY;
      px = int'(WIN_X); py = int'(WIN_Y); pb = int'(BIT_SEL); pm = int'(TAP_MASK);
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, FETCH_REQ, 0);
    chk({tag, "_vld"}, OPU_VLD, 0);
    chk({tag, "_x"}, int'(WIN_X), 0);
    chk({tag, "_y"}, int'(WIN_Y), 0);
    chk({tag, "_bit"}, int'(BIT_SEL), 0);
    chk({tag, "_mask"}, int'(TAP_MASK), 0);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_done"}, DONE, 0);
  endtask

  task automatic start_scan(input int ps, input int p, input bit tie, input int ad, input int rd);
    build(ps, p);
    tie_hi = tie; ack_dly = ad; rdy_dly = rd;
    idx = 0; done_cnt = 0; check_spacing = tie; mon_en = 1'b1;
    m_first = 0; m_66 = 0;
    @(negedge SYS_CLK);
    PIC_SIZE = 8'(ps); PADDING = p[0]; START = 1'b1;
    @(negedge SYS_CLK);
    START = 1'b0;
    // Scrambled after START to show the geometry was latched.
    PIC_SIZE = 8'd3; PADDING = ~p[0];
    chk("req_after_start", FETCH_REQ, 1);
    chk("busy_after_start", BUSY, 1);
  endtask

  task automatic run_scan(input vec_t v, input string name);
    int n = 0;
    start_scan(v.ps, v.pad, v.tie, v.ad, v.rd);
    while (done_cnt == 0 && n < 30000) begin
      @(negedge SYS_CLK);
      n++;
      START = (v.restart != 0 && n == v.restart);
      if (START) PIC_SIZE = 8'd5;
    end
    START = 1'b0;
    if (n >= 30000) chk({name, "_timeout"}, 0, 1);
    repeat (3) @(negedge SYS_CLK);
    chk({name, "_beats"}, idx, v.beats);
    chk({name, "_done_pulses"}, done_cnt, 1);
    chk({name, "_busy_idle"}, BUSY, 0);
    mon_en = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{8, 0, 1'b1, 0, 0, 0, 288};
    vecs[1] = '{8, 1, 1'b1, 0, 0, 0, 512};
    vecs[2] = '{5, 0, 1'b1, 0, 0, 0, 72};
    vecs[3] = '{8, 0, 1'b0, 5, 20, 0, 288};
    vecs[4] = '{8, 0, 1'b1, 0, 0, 37, 288};
    vecs[5] = '{3, 1, 1'b0, 1, 2, 0, 72};

    repeat (2) @(negedge SYS_CLK);
    chk_all_zero("reset");
    SYS_RST = 1'b1;
    @(negedge SYS_CLK);
    chk_all_zero("idle");

    for (int i = 0; i < 6; i++) begin
      run_scan(vecs[i], $sformatf("vec%0d", i));
      if (i == 0) begin
        chk("vec0_last_x", last_x, 4);
        chk("vec0_last_y", last_y, 5);
        chk("vec0_last_bit", last_b, 7);
      end
      if (i == 1) begin
        chk("pad_first_mask", m_first, 9'b111100100);
        chk("pad_66_mask", m_66, 9'b001001111);
      end
    end

    // Asynchronous reset in the middle of beat 100, then a clean restart.
    start_scan(8, 0, 1'b1, 0, 0);
    n = 0;
    while (idx < 100 && n < 2000) begin @(negedge SYS_CLK); n++; end
    if (n >= 2000) chk("reset_wait_timeout", 0, 1);
    mon_en = 1'b0;
    #2 SYS_RST = 1'b0;
    #1 chk_all_zero("midreset");
    @(negedge SYS_CLK);
    SYS_RST = 1'b1;
    run_scan(vecs[0], "after_reset");

    // Degenerate image: DONE next cycle, no beats, BUSY never rises.
    build(2, 0);
    idx = 0; done_cnt = 0; mon_en = 1'b1; tie_hi = 1'b1;
    @(negedge SYS_CLK);
    PIC_SIZE = 8'd2; PADDING = 1'b0; START = 1'b1;
    @(negedge SYS_CLK);
    START = 1'b0;
    chk("small_done", DONE, 1);
    chk("small_busy", BUSY, 0);
    chk("small_req", FETCH_REQ, 0);
    @(negedge SYS_CLK);
    chk("small_done_pulse", DONE, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge SYS_CLK);
      chk("small_busy_stays_low", BUSY, 0);
    end
    chk("small_beats", idx, 0);
    chk("small_done_count", done_cnt, 1);
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
